// File: rtl/seg_scan_blink_pkg.sv
// ============================================================================
// Module      : seg_scan_blink_pkg
// Description : Shared display constants: hex-to-7-segment table, blank levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_blink_pkg;

  localparam logic [7:0] AN_BLANK  = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       DP_BLANK  = 1'b1;

  // Active-low {g,f,e,d,c,b,a}; entry n decodes hex digit n (index 15 first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  blink;
    logic [7:0]  dp;
  } snap_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_blink_hex7seg.sv
// ============================================================================
// Module      : hex7seg
// Description : Combinational 4-bit hex to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
  import seg_scan_blink_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_to_seg(i_hex);
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_blink.sv
// ============================================================================
// Module      : seg_scan_blink
// Description : 8-digit multiplexed 7-segment scanner with per-digit blink,
//               anti-ghost blanking and frame-coherent input snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_blink
  import seg_scan_blink_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  blink,
  input  logic [7:0]  dp,
  input  logic        en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] C_P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] C_P_BLANK = PW'(BLANK_CYC);
  localparam logic [BW-1:0] C_B_LAST  = BW'(BLINK_DIV - 1);

  logic [PW-1:0] r_p;
  logic [2:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          r_primed;
  snap_t         r_snap;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dpn;

  logic          w_p_wrap;
  logic          w_b_wrap;
  logic          w_frame_end;
  logic          w_active;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  assign w_p_wrap    = (r_p == C_P_LAST);
  assign w_b_wrap    = (r_bcnt == C_B_LAST);
  assign w_frame_end = w_p_wrap && (r_idx == 3'd7);
  assign w_nib       = r_snap.data[{r_idx, 2'b00} +: 4];
  assign w_active    = en && (r_p >= C_P_BLANK) && !(r_snap.blink[r_idx] && r_phase);

  hex7seg u_hex7seg (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_p    <= w_p_wrap ? '0 : r_p + 1'b1;
      r_bcnt <= w_b_wrap ? '0 : r_bcnt + 1'b1;
      if (w_p_wrap) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_b_wrap) begin
        r_phase <= ~r_phase;
      end
    end
  end

  // Snapshot reloads only at frame end so a displayed frame never mixes old and new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (!r_primed || w_frame_end) begin
        r_snap.data  <= data;
        r_snap.blink <= blink;
        r_snap.dp    <= dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
      r_dpn <= DP_BLANK;
    end else if (w_active) begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= w_seg;
      r_dpn <= ~r_snap.dp[r_idx];
    end else begin
      r_an  <= AN_BLANK;
      r_seg <= SEG_BLANK;
      r_dpn <= DP_BLANK;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp_n = r_dpn;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_blink.sv
// ============================================================================
// Module      : tb_seg_scan_blink
// Description : Self-checking bench for seg_scan_blink against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_blink;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [7:0]  blink;
  logic [7:0]  dp;
  logic        en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_blink #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .blink (blink),
    .dp    (dp),
    .en    (en),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: everything derives from k, the number of edges since reset release.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  int          m_k;
  logic [31:0] m_sdata;
  logic [7:0]  m_sblink;
  logic [7:0]  m_sdp;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dpn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k      = 0;
      m_sdata  = '0;
      m_sblink = '0;
      m_sdp    = '0;
      exp_an   = 8'hFF;
      exp_seg  = 7'h7F;
      exp_dpn  = 1'b1;
    end else begin
      int p, d, ph;
      p  = m_k % SCAN_DIV;
      d  = (m_k / SCAN_DIV) % 8;
      ph = (m_k / BLINK_DIV) % 2;
      if (en && p >= BLANK_CYC && !(m_sblink[d] && ph == 1)) begin
        exp_an  = 8'hFF;
        exp_an[d] = 1'b0;
        exp_seg = seg_tab[(m_sdata >> (4 * d)) & 32'hF];
        exp_dpn = ~m_sdp[d];
      end else begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dpn = 1'b1;
      end
      if (m_k == 0 || (m_k % FRAME) == FRAME - 1) begin
        m_sdata  = data;
        m_sblink = blink;
        m_sdp    = dp;
      end
      m_k = m_k + 1;
    end
  end

  logic cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("outputs{an,seg,dp_n}", {16'h0, an, seg, dp_n}, {16'h0, exp_an, exp_seg, exp_dpn});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic release_and_pin(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check({tag, "_edge1_an"}, {24'h0, an}, 32'hFF);
    @(posedge clk); #1;
    check({tag, "_edge2_an"}, {24'h0, an}, 32'hFF);
    @(posedge clk); #1;
    check({tag, "_edge3_an"}, {24'h0, an}, 32'hFE);
    check({tag, "_edge3_seg"}, {25'h0, seg}, 32'h40);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_edge11_an"}, {24'h0, an}, 32'hFD);
    check({tag, "_edge11_seg"}, {25'h0, seg}, 32'h79);
  endtask

  initial begin
    rst_n = 1'b0;
    data  = 32'h76543210;
    blink = 8'h00;
    dp    = 8'h00;
    en    = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {16'h0, an, seg, dp_n}, {16'h0, 8'hFF, 7'h7F, 1'b1});

    release_and_pin("first");
    repeat (120) @(negedge clk);

    data = 32'hFEDCBA98;
    dp   = 8'hA5;
    repeat (200) @(negedge clk);

    blink = 8'h04;
    repeat (300) @(negedge clk);
    blink = 8'h00;

    // Change data mid-frame while digit 3 is being scanned.
    data = 32'h0;
    repeat (140) @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (((m_k / SCAN_DIV) % 8) == 3) break;
      @(negedge clk);
    end
    data = 32'h11111111;
    repeat (150) @(negedge clk);

    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) data  = $urandom;
      if ($urandom_range(0, 15) == 0) blink = 8'($urandom);
      if ($urandom_range(0, 15) == 0) dp    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) en    = ~en;
    end

    // Asynchronous reset in the middle of digit 5's slot.
    en    = 1'b1;
    blink = 8'h00;
    for (int i = 0; i < 200; i++) begin
      if ((m_k % FRAME) == 5 * SCAN_DIV + 4) break;
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_an", {24'h0, an}, 32'hFF);
    check("async_reset_seg", {25'h0, seg}, 32'h7F);
    check("async_reset_dpn", {31'h0, dp_n}, 32'h1);
    data = 32'h76543210;
    repeat (3) @(negedge clk);
    release_and_pin("after_reset");
    repeat (200) @(negedge clk);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
